// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin arbiter that shares one AXI4 read port between
// the MM2S data-fetch engine (s0) and the SG descriptor-fetch engine (s1).
// Only one burst is in flight at a time. The AR side is registered. The R
// side is routed combinationally to whichever requester holds the grant.
module axi_rd_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  axi_aclk,
   input  logic                  axi_reset,
   // requester 0
   input  logic [ADDR_WIDTH-1:0] s0_araddr,
   input  logic [7:0]            s0_arlen,
   input  logic [2:0]            s0_arsize,
   input  logic [1:0]            s0_arburst,
   input  logic                  s0_arvalid,
   output logic                  s0_arready,
   output logic [DATA_WIDTH-1:0] s0_rdata,
   output logic [1:0]            s0_rresp,
   output logic                  s0_rlast,
   output logic                  s0_rvalid,
   input  logic                  s0_rready,
   // requester 1
   input  logic [ADDR_WIDTH-1:0] s1_araddr,
   input  logic [7:0]            s1_arlen,
   input  logic [2:0]            s1_arsize,
   input  logic [1:0]            s1_arburst,
   input  logic                  s1_arvalid,
   output logic                  s1_arready,
   output logic [DATA_WIDTH-1:0] s1_rdata,
   output logic [1:0]            s1_rresp,
   output logic                  s1_rlast,
   output logic                  s1_rvalid,
   input  logic                  s1_rready,
   // master AR channel
   output logic [ADDR_WIDTH-1:0] m_araddr,
   output logic [7:0]            m_arlen,
   output logic [2:0]            m_arsize,
   output logic [1:0]            m_arburst,
   output logic [2:0]            m_arprot,
   output logic [3:0]            m_arcache,
   output logic                  m_arvalid,
   input  logic                  m_arready,
   // master R channel
   input  logic [DATA_WIDTH-1:0] m_rdata,
   input  logic [1:0]            m_rresp,
   input  logic                  m_rlast,
   input  logic                  m_rvalid,
   output logic                  m_rready,
   // status
   output logic                  grant_id,
   output logic                  busy,
   output logic                  len_err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   logic [1:0]            r_state;
   logic                  r_grant_id;
   logic                  r_last_grant;
   logic [7:0]            r_beat_cnt;
   logic [7:0]            r_beat_target;
   logic                  r_len_err;
   logic                  r_arvalid;
   logic [ADDR_WIDTH-1:0] r_araddr;
   logic [7:0]            r_arlen;
   logic [2:0]            r_arsize;
   logic [1:0]            r_arburst;

   logic                  w_win_id;
   logic                  w_grant_fire;
   logic                  w_in_data;
   logic                  w_sel_rready;
   logic                  w_r_hs;

   // Pick the winner: a lone request wins; on a tie the side not served last wins
   always_comb begin
      w_win_id = 1'b0;
      if (s0_arvalid && s1_arvalid) begin
         w_win_id = ~r_last_grant;
      end else if (s1_arvalid) begin
         w_win_id = 1'b1;
      end else begin
         w_win_id = 1'b0;
      end
   end

   assign w_grant_fire = (r_state == ST_IDLE) && (s0_arvalid || s1_arvalid) && !axi_reset;
   assign s0_arready   = w_grant_fire && !w_win_id;
   assign s1_arready   = w_grant_fire &&  w_win_id;

   // Route the slave R channel to the granted requester; the other side sees zeros
   always_comb begin
      w_in_data    = (r_state == ST_DATA) && !axi_reset;
      w_sel_rready = 1'b0;
      s0_rvalid    = 1'b0;
      s0_rlast     = 1'b0;
      s0_rdata     = {DATA_WIDTH{1'b0}};
      s0_rresp     = 2'b00;
      s1_rvalid    = 1'b0;
      s1_rlast     = 1'b0;
      s1_rdata     = {DATA_WIDTH{1'b0}};
      s1_rresp     = 2'b00;
      if (w_in_data && r_grant_id) begin
         w_sel_rready = s1_rready;
         s1_rvalid    = m_rvalid;
         s1_rlast     = m_rlast;
         s1_rdata     = m_rdata;
         s1_rresp     = m_rresp;
      end else if (w_in_data) begin
         w_sel_rready = s0_rready;
         s0_rvalid    = m_rvalid;
         s0_rlast     = m_rlast;
         s0_rdata     = m_rdata;
         s0_rresp     = m_rresp;
      end else begin
         w_sel_rready = 1'b0;
      end
   end

   assign m_rready = w_sel_rready;
   assign w_r_hs   = m_rvalid && w_sel_rready;

   // Sequencing FSM: capture the winner, hold AR until accepted, count R beats
   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         r_state       <= ST_IDLE;
         r_grant_id    <= 1'b0;
         r_last_grant  <= 1'b1;
         r_beat_cnt    <= 8'd0;
         r_beat_target <= 8'd0;
         r_len_err     <= 1'b0;
         r_arvalid     <= 1'b0;
         r_araddr      <= {ADDR_WIDTH{1'b0}};
         r_arlen       <= 8'd0;
         r_arsize      <= 3'd0;
         r_arburst     <= 2'd0;
      end else begin
         r_len_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_grant_fire) begin
                  r_grant_id    <= w_win_id;
                  r_araddr      <= w_win_id ? s1_araddr  : s0_araddr;
                  r_arlen       <= w_win_id ? s1_arlen   : s0_arlen;
                  r_arsize      <= w_win_id ? s1_arsize  : s0_arsize;
                  r_arburst     <= w_win_id ? s1_arburst : s0_arburst;
                  r_beat_target <= w_win_id ? s1_arlen   : s0_arlen;
                  r_arvalid     <= 1'b1;
                  r_state       <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (m_arready) begin
                  r_arvalid  <= 1'b0;
                  r_beat_cnt <= 8'd0;
                  r_state    <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_r_hs) begin
                  if (m_rlast) begin
                     // beat_cnt holds the index of this final beat, which must equal arlen
                     r_len_err    <= (r_beat_cnt != r_beat_target);
                     r_last_grant <= r_grant_id;
                     r_state      <= ST_IDLE;
                  end else if (r_beat_cnt != 8'hFF) begin
                     r_beat_cnt <= r_beat_cnt + 8'd1;
                  end
               end
            end
            default: begin
               r_arvalid <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign m_araddr  = r_araddr;
   assign m_arlen   = r_arlen;
   assign m_arsize  = r_arsize;
   assign m_arburst = r_arburst;
   assign m_arprot  = 3'b000;
   assign m_arcache = 4'b0011;
   assign m_arvalid = r_arvalid;
   assign grant_id  = r_grant_id;
   assign busy      = (r_state != ST_IDLE);
   assign len_err   = r_len_err;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed bench for the two-requester AXI read arbiter.
// Inputs change just after the falling edge; outputs are checked 1 ns later.
module tb_axi_rd_arbiter;

   logic        axi_aclk = 1'b0;
   logic        axi_reset;
   logic [31:0] s0_araddr, s1_araddr;
   logic [7:0]  s0_arlen, s1_arlen;
   logic [2:0]  s0_arsize, s1_arsize;
   logic [1:0]  s0_arburst, s1_arburst;
   logic        s0_arvalid, s1_arvalid;
   logic        s0_arready, s1_arready;
   logic [31:0] s0_rdata, s1_rdata;
   logic [1:0]  s0_rresp, s1_rresp;
   logic        s0_rlast, s1_rlast, s0_rvalid, s1_rvalid;
   logic        s0_rready, s1_rready;
   logic [31:0] m_araddr;
   logic [7:0]  m_arlen;
   logic [2:0]  m_arsize;
   logic [1:0]  m_arburst;
   logic [2:0]  m_arprot;
   logic [3:0]  m_arcache;
   logic        m_arvalid, m_arready;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;
   logic        m_rlast, m_rvalid, m_rready;
   logic        grant_id, busy, len_err;

   int total_cnt = 0;
   int bad_cnt   = 0;

   always #5 axi_aclk = ~axi_aclk;

   axi_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .axi_aclk(axi_aclk), .axi_reset(axi_reset),
      .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
      .s0_arburst(s0_arburst), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
      .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
      .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
      .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
      .s1_arburst(s1_arburst), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
      .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
      .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
      .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_arburst(m_arburst), .m_arprot(m_arprot), .m_arcache(m_arcache),
      .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
      .m_rvalid(m_rvalid), .m_rready(m_rready),
      .grant_id(grant_id), .busy(busy), .len_err(len_err)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge axi_aclk);
   endtask

   // Caller has already raised the arvalid(s). Checks the grant, the AR
   // registers while slave arready stays low for dly cycles, then accepts.
   task automatic grant_step(input int id, input logic [31:0] addr,
                             input logic [7:0] len, input int dly, input bit drop);
      #1;
      chk("arready0", s0_arready, (id == 0));
      chk("arready1", s1_arready, (id == 1));
      tick();
      if (drop && id == 0) s0_arvalid = 1'b0;
      if (drop && id == 1) s1_arvalid = 1'b0;
      for (int k = 0; k <= dly; k++) begin
         #1;
         chk("m_arvalid", m_arvalid, 1);
         chk("m_araddr", m_araddr, addr);
         chk("m_arlen", m_arlen, len);
         chk("grant_id", grant_id, id);
         chk("busy_addr", busy, 1);
         chk("ar_blocked", s0_arready | s1_arready, 0);
         if (k == dly) m_arready = 1'b1;
         tick();
      end
      m_arready = 1'b0;
   endtask

   // One accepted R beat with both requesters ready
   task automatic beat(input int id, input logic [31:0] data, input bit last,
                       input logic [1:0] resp);
      m_rvalid = 1'b1; m_rdata = data; m_rlast = last; m_rresp = resp;
      s0_rready = 1'b1; s1_rready = 1'b1;
      #1;
      chk("m_rready", m_rready, 1);
      chk("g_rvalid", (id == 0) ? s0_rvalid : s1_rvalid, 1);
      chk("g_rdata", (id == 0) ? s0_rdata : s1_rdata, data);
      chk("g_rlast", (id == 0) ? s0_rlast : s1_rlast, last);
      chk("g_rresp", (id == 0) ? s0_rresp : s1_rresp, resp);
      chk("o_rvalid", (id == 0) ? s1_rvalid : s0_rvalid, 0);
      chk("o_rdata", (id == 0) ? s1_rdata : s0_rdata, 0);
      chk("busy_data", busy, 1);
      tick();
      m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
   endtask

   task automatic do_reset();
      axi_reset = 1'b1;
      tick();
      tick();
      axi_reset = 1'b0;
   endtask

   initial begin
      axi_reset = 1'b1;
      s0_araddr = 32'h0; s0_arlen = 8'd0; s0_arsize = 3'd2; s0_arburst = 2'd1;
      s1_araddr = 32'h0; s1_arlen = 8'd0; s1_arsize = 3'd2; s1_arburst = 2'd1;
      s0_arvalid = 1'b0; s1_arvalid = 1'b0; s0_rready = 1'b0; s1_rready = 1'b0;
      m_arready = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00; m_rlast = 1'b0; m_rvalid = 1'b0;

      // reset state, with a request pending that must be ignored
      tick();
      s0_arvalid = 1'b1;
      #1;
      chk("rst_arready0", s0_arready, 0);
      do_reset();
      s0_arvalid = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_arvalid", m_arvalid, 0);
      chk("rst_araddr", m_araddr, 0);
      chk("rst_len_err", len_err, 0);
      chk("rst_rready", m_rready, 0);
      chk("arprot", m_arprot, 0);
      chk("arcache", m_arcache, 3);
      tick();

      // single s0 request, 4 beats, slave arready after 2 cycles
      s0_arvalid = 1'b1; s0_araddr = 32'h1000; s0_arlen = 8'd3;
      grant_step(0, 32'h1000, 8'd3, 2, 1'b1);
      chk("t1_arsize", m_arsize, 2);
      for (int i = 0; i < 4; i++) beat(0, 32'hA0 + i, (i == 3), (i == 1) ? 2'b10 : 2'b00);
      #1;
      chk("t1_busy_end", busy, 0);
      chk("t1_len_err", len_err, 0);
      tick();

      // simultaneous requests after reset: s0 first, then s1
      do_reset();
      s0_arvalid = 1'b1; s0_araddr = 32'h2000; s0_arlen = 8'd0;
      s1_arvalid = 1'b1; s1_araddr = 32'h3000; s1_arlen = 8'd0;
      grant_step(0, 32'h2000, 8'd0, 0, 1'b1);
      beat(0, 32'hB0, 1'b1, 2'b00);
      grant_step(1, 32'h3000, 8'd0, 0, 1'b1);
      beat(1, 32'hC0, 1'b1, 2'b00);
      #1;
      chk("t2_busy_end", busy, 0);
      tick();

      // round-robin: both hold arvalid for 6 bursts
      s0_arvalid = 1'b1; s0_araddr = 32'h4000; s0_arlen = 8'd0;
      s1_arvalid = 1'b1; s1_araddr = 32'h5000; s1_arlen = 8'd0;
      for (int k = 0; k < 6; k++) begin
         grant_step(k % 2, (k % 2 == 0) ? 32'h4000 : 32'h5000, 8'd0, 0, 1'b0);
         beat(k % 2, 32'h50 + k, 1'b1, 2'b00);
      end
      s0_arvalid = 1'b0; s1_arvalid = 1'b0;
      tick();

      // backpressure on s1, arlen=1
      s1_arvalid = 1'b1; s1_araddr = 32'h6000; s1_arlen = 8'd1;
      grant_step(1, 32'h6000, 8'd1, 0, 1'b1);
      m_rvalid = 1'b1; m_rdata = 32'hD0; m_rlast = 1'b0;
      s1_rready = 1'b0; s0_rready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_rready", m_rready, 0);
         chk("bp_rvalid", s1_rvalid, 1);
         chk("bp_rdata", s1_rdata, 32'hD0);
         tick();
      end
      beat(1, 32'hD0, 1'b0, 2'b00);
      beat(1, 32'hD1, 1'b1, 2'b00);
      #1;
      chk("bp_len_err", len_err, 0);
      chk("bp_busy_end", busy, 0);
      tick();

      // length error: arlen=3 but rlast on 2nd beat
      s0_arvalid = 1'b1; s0_araddr = 32'h7000; s0_arlen = 8'd3;
      grant_step(0, 32'h7000, 8'd3, 0, 1'b1);
      beat(0, 32'hE0, 1'b0, 2'b00);
      beat(0, 32'hE1, 1'b1, 2'b00);
      #1;
      chk("le_pulse", len_err, 1);
      chk("le_idle", busy, 0);
      tick();
      #1;
      chk("le_clear", len_err, 0);
      tick();
      s0_arvalid = 1'b1; s0_araddr = 32'h7100; s0_arlen = 8'd0;
      grant_step(0, 32'h7100, 8'd0, 0, 1'b1);
      beat(0, 32'hE2, 1'b1, 2'b00);
      #1;
      chk("le_next_ok", len_err, 0);
      tick();

      // reset in the middle of an s1 arlen=7 burst
      s1_arvalid = 1'b1; s1_araddr = 32'h8000; s1_arlen = 8'd7;
      grant_step(1, 32'h8000, 8'd7, 0, 1'b1);
      beat(1, 32'hF0, 1'b0, 2'b00);
      m_rvalid = 1'b1; m_rdata = 32'hF1; s1_rready = 1'b1;
      axi_reset = 1'b1;
      #1;
      chk("mr_gate_rready", m_rready, 0);
      chk("mr_gate_rvalid", s1_rvalid, 0);
      tick();
      axi_reset = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
      #1;
      chk("mr_busy", busy, 0);
      chk("mr_arvalid", m_arvalid, 0);
      chk("mr_rready", m_rready, 0);
      chk("mr_grant", grant_id, 0);
      chk("mr_araddr", m_araddr, 0);
      tick();
      s0_arvalid = 1'b1; s0_araddr = 32'h9000; s0_arlen = 8'd0;
      s1_arvalid = 1'b1; s1_araddr = 32'h9100; s1_arlen = 8'd0;
      grant_step(0, 32'h9000, 8'd0, 0, 1'b1);
      beat(0, 32'h99, 1'b1, 2'b00);
      s1_arvalid = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
